lsu_stage: RTL and testbench
============================

# lsu_stage

Memory-access stage that sits directly downstream of the ALU. It takes the ALU result as either a writeback value or an effective address, and issues aligned word-bus transactions with byte enables over a req/ack handshake. It also extracts and extends load data and flags misaligned or illegal accesses. It stalls the upstream stage while a bus transaction is outstanding.

## Interface
Parameters:
- `WORD_LEN`, default 32: datapath width. Only 32 is supported.

Ports:
- `clk`, input, 1: the single clock; rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: an EX-stage op is presented.
- `in_ready`, output, 1: combinational, equal to (state == IDLE); the op is accepted on an edge where `in_valid & in_ready`.
- `in_ALUOut`, input, 32: ALU result; also the effective address for memory ops.
- `in_storeData`, input, 32: rs2 value for stores.
- `in_memRead`, input, 1: op is a load.
- `in_memWrite`, input, 1: op is a store.
- `in_funct3`, input, 3: access size and sign (RV32I encoding).
- `in_regWrite`, input, 1: op writes rd.
- `in_rd`, input, 5: destination register.
- `mem_req`, output, 1: bus request, registered.
- `mem_we`, output, 1: 1 = write.
- `mem_addr`, output, 32: word-aligned address ({addr[31:2], 2'b00}).
- `mem_be`, output, 4: byte enables.
- `mem_wdata`, output, 32: lane-replicated store data.
- `mem_ack`, input, 1: transfer completes on an edge where `mem_req & mem_ack`.
- `mem_rdata`, input, 32: read word; valid when `mem_ack` is high.
- `out_valid`, output, 1: one-cycle writeback pulse.
- `out_data`, output, 32: writeback value.
- `out_rd`, output, 5: destination register.
- `out_regWrite`, output, 1: write enable for the register file.
- `out_fault`, output, 1: misaligned or illegal access.

## Operation
- The state machine has two states, IDLE and BUS. Reset enters IDLE.
- **IDLE, accepted op with neither memRead nor memWrite (ALU pass-through):**
  - next cycle: `out_valid`=1, `out_data`=`in_ALUOut`, `out_rd`=`in_rd`, `out_regWrite`=`in_regWrite`;
  - remain in IDLE.
- **Fault conditions**, checked at accept:
  - memRead and memWrite both set;
  - load funct3 in {011, 110, 111};
  - store funct3 > 010;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠00.
- **Faulting op:**
  - next cycle: `out_valid`=1, `out_fault`=1, `out_regWrite`=0, `out_data`=`in_ALUOut` (the faulting address);
  - no bus request; remain in IDLE.
- **Valid memory op:** register `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`, and latch rd/funct3/regWrite/addr[1:0]; set `mem_req`=1; go to BUS.
- **Byte enables and write data:**
  - SB/LB/LBU: be = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH/LH/LHU: be = 0011 or 1100 per addr[1]; wdata = halfword replicated ×2.
  - SW/LW: be = 1111.
  - Loads drive `mem_wdata`=0.
- **BUS:** all `mem_*` outputs are held stable until ack. On the ack edge:
  - `mem_req` goes to 0 and the FSM returns to IDLE;
  - `out_valid`=1, `out_rd` = latched rd, `out_fault`=0.
- **Load completion:**
  - select lane by the latched addr[1:0];
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word;
  - `out_regWrite` = latched regWrite.
- **Store completion:** `out_regWrite`=0; `out_data`=0.
- **`out_*` outside a valid pulse:** `out_valid`=0 and `out_regWrite`=0 in every cycle without a pulse; `out_data`/`out_rd`/`out_fault` keep their last values.
- **Spurious acks:** `mem_ack` while `mem_req`=0 is ignored.
- **Reset mid-transaction:**
  - all registers clear immediately; `mem_req` drops asynchronously;
  - the pending op is discarded with no `out_valid`;
  - a late ack after reset release is ignored.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_be` 0, `mem_wdata` 0, `out_valid` 0, `out_data` 0, `out_rd` 0, `out_regWrite` 0, `out_fault` 0. `in_ready` therefore reads 1.
- Pass-through and fault latency: 1 cycle (accept edge E0 → `out_valid` high after E0). Throughput is 1 op per cycle.
- Memory op:
  - `mem_req` rises after accept edge E0;
  - if `mem_ack` is sampled high at edge E0+1+N (N ≥ 0 wait cycles), `out_valid` is high for the cycle after that edge;
  - minimum latency is 2 cycles.
- `in_ready` is 0 for exactly 1+N cycles per memory op. The next op can be accepted at the ack edge + 1.
- There is no backpressure from writeback; `out_valid` is always a single-cycle pulse.

## Test plan
- **Pass-through:** accept with `in_ALUOut`=0x0000_1234, rd=5, regWrite=1, no mem flags → next cycle `out_valid`=1, `out_data`=0x0000_1234, `out_rd`=5, `out_regWrite`=1, `mem_req` never 1. Repeat back-to-back for 4 cycles: 4 consecutive pulses.
- **Loads:**
  - LB at 0x0000_1003, `mem_rdata`=0x8000_0000, ack in the first BUS cycle → `mem_addr`=0x0000_1000, `mem_be`=1000, `out_data`=0xFFFF_FF80 exactly 2 cycles after accept.
  - Same access as LBU → 0x0000_0080.
- **Store with wait states:** SH at 0x0000_2002, storeData=0x0000_ABCD, ack after 3 wait cycles → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCD_ABCD, held 4 cycles; `in_ready`=0 for 4 cycles; `out_valid`=1 with `out_regWrite`=0.
- **Faults:** LW at 0x0000_1002 → next cycle `out_fault`=1, `out_data`=0x0000_1002, `out_regWrite`=0, `mem_req` stays 0. Repeat with memRead=memWrite=1 → same fault response.
- **Reset mid-transaction:** assert `rst` mid-cycle while in BUS → `mem_req` 0 before the next edge, no `out_valid`. Ack arriving after release is ignored; `in_ready`=1.
- **Spurious ack:** `mem_ack`=1 while IDLE → no state change, no `out_valid`.

Source files
------------

// File: rtl/lsu_stage.sv
// lsu_stage: load/store stage issuing aligned word-bus transfers with byte enables and load extension
module lsu_stage #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_LEN-1:0] in_ALUOut,
    input  logic [WORD_LEN-1:0] in_storeData,
    input  logic                in_memRead,
    input  logic                in_memWrite,
    input  logic [2:0]          in_funct3,
    input  logic                in_regWrite,
    input  logic [4:0]          in_rd,
    output logic                mem_req,
    output logic                mem_we,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic [3:0]          mem_be,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [WORD_LEN-1:0] mem_rdata,
    output logic                out_valid,
    output logic [WORD_LEN-1:0] out_data,
    output logic [4:0]          out_rd,
    output logic                out_regWrite,
    output logic                out_fault
);
    typedef enum logic {IDLE, BUS} state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [WORD_LEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [4:0]          rd_q, rd_d, out_rd_q, out_rd_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          lo_q, lo_d;
    logic                rw_q, rw_d;
    logic                out_valid_q, out_valid_d, out_rw_q, out_rw_d, out_fault_q, out_fault_d;
    logic [WORD_LEN-1:0] out_data_q, out_data_d;

    logic                is_mem, fault;
    logic [1:0]          sz, a_lo;
    logic [3:0]          be;
    logic [WORD_LEN-1:0] wdata, ld;
    logic [7:0]          lb;
    logic [15:0]         lh;

    // access decode, fault detection and load-lane extraction
    always_comb begin
        a_lo   = in_ALUOut[1:0];
        sz     = in_funct3[1:0];
        is_mem = in_memRead | in_memWrite;
        fault  = (in_memRead & in_memWrite)
               | (in_memRead & (in_funct3 == 3'b011 || in_funct3 == 3'b110 || in_funct3 == 3'b111))
               | (in_memWrite & (in_funct3 > 3'b010))
               | (is_mem & sz == 2'b01 & a_lo[0])
               | (is_mem & sz == 2'b10 & a_lo != 2'b00);
        be     = sz == 2'b00 ? 4'b0001 << a_lo : sz == 2'b01 ? (a_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata  = !in_memWrite ? '0 : sz == 2'b00 ? {4{in_storeData[7:0]}} :
                 sz == 2'b01 ? {2{in_storeData[15:0]}} : in_storeData;
        lb     = mem_rdata[{lo_q, 3'b000} +: 8];
        lh     = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld     = f3_q[1] ? mem_rdata : f3_q[0] ? {{16{~f3_q[2] & lh[15]}}, lh} : {{24{~f3_q[2] & lb[7]}}, lb};
    end

    // next-state: accept in IDLE, hold the bus request in BUS until acknowledged
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rd_d        = rd_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        rw_d        = rw_q;
        out_valid_d = 1'b0;
        out_rw_d    = 1'b0;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_fault_d = out_fault_q;
        if (state_q == IDLE) begin
            if (in_valid && (fault || !is_mem)) begin
                out_valid_d = 1'b1;
                out_fault_d = fault;
                out_rw_d    = fault ? 1'b0 : in_regWrite;
                out_data_d  = in_ALUOut;
                out_rd_d    = in_rd;
            end else if (in_valid) begin
                state_d     = BUS;
                mem_req_d   = 1'b1;
                mem_we_d    = in_memWrite;
                mem_addr_d  = {in_ALUOut[WORD_LEN-1:2], 2'b00};
                mem_be_d    = be;
                mem_wdata_d = wdata;
                rd_d        = in_rd;
                f3_d        = in_funct3;
                lo_d        = a_lo;
                rw_d        = in_regWrite;
            end
        end else if (mem_req_q && mem_ack) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            out_valid_d = 1'b1;
            out_fault_d = 1'b0;
            out_rd_d    = rd_q;
            out_rw_d    = mem_we_q ? 1'b0 : rw_q;
            out_data_d  = mem_we_q ? '0 : ld;
        end
    end

    // state registers; reset discards any outstanding transfer immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rd_q        <= '0;
            f3_q        <= '0;
            lo_q        <= '0;
            rw_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_rw_q    <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rd_q        <= rd_d;
            f3_q        <= f3_d;
            lo_q        <= lo_d;
            rw_q        <= rw_d;
            out_valid_q <= out_valid_d;
            out_rw_q    <= out_rw_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_fault_q <= out_fault_d;
        end
    end

    assign in_ready     = state_q == IDLE;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_rd       = out_rd_q;
    assign out_regWrite = out_rw_q;
    assign out_fault    = out_fault_q;
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed vectors with hand-computed expectations for lsu_stage
module tb_lsu_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_ALUOut = '0, in_storeData = '0;
    logic        in_memRead = 1'b0, in_memWrite = 1'b0, in_regWrite = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    logic        out_valid, out_regWrite, out_fault;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    int          n_tests = 0, n_fail = 0;

    lsu_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ALUOut(in_ALUOut), .in_storeData(in_storeData), .in_memRead(in_memRead),
        .in_memWrite(in_memWrite), .in_funct3(in_funct3), .in_regWrite(in_regWrite),
        .in_rd(in_rd), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
        .out_regWrite(out_regWrite), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    // compare one observed value against its expectation
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic r, input logic w, input logic [2:0] f3,
                      input logic [4:0] rd, input logic rw, input logic [31:0] sd);
        in_valid = 1'b1; in_ALUOut = a; in_memRead = r; in_memWrite = w;
        in_funct3 = f3; in_rd = rd; in_regWrite = rw; in_storeData = sd;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_memRead = 1'b0; in_memWrite = 1'b0;
    endtask

    // load with ack in the first bus cycle: result visible two edges after accept
    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] ex_addr,
                           input logic [3:0] ex_be, input logic [31:0] ex_data);
        op(a, 1'b1, 1'b0, f3, 5'd7, 1'b1, 32'hDEAD_BEEF);
        step();
        chk({tag, "_req"}, 32'(mem_req), 1);
        chk({tag, "_addr"}, mem_addr, ex_addr);
        chk({tag, "_be"}, 32'(mem_be), 32'(ex_be));
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_rdy0"}, 32'(in_ready), 0);
        chk({tag, "_nov"}, 32'(out_valid), 0);
        idle_in();
        mem_ack = 1'b1; mem_rdata = rdata;
        step();
        mem_ack = 1'b0;
        chk({tag, "_ov"}, 32'(out_valid), 1);
        chk({tag, "_data"}, out_data, ex_data);
        chk({tag, "_rd"}, 32'(out_rd), 7);
        chk({tag, "_rw"}, 32'(out_regWrite), 1);
        chk({tag, "_fault"}, 32'(out_fault), 0);
        chk({tag, "_reqlo"}, 32'(mem_req), 0);
        chk({tag, "_rdy1"}, 32'(in_ready), 1);
    endtask

    initial begin
        #2;
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_fault", 32'(out_fault), 0);
        #4 rst = 1'b0;
        step();
        op(32'h0000_1234, 1'b0, 1'b0, 3'b010, 5'd5, 1'b1, '0);
        step();
        chk("pt_ov", 32'(out_valid), 1);
        chk("pt_data", out_data, 32'h0000_1234);
        chk("pt_rd", 32'(out_rd), 5);
        chk("pt_rw", 32'(out_regWrite), 1);
        chk("pt_req", 32'(mem_req), 0);
        for (int i = 0; i < 4; i++) begin
            in_ALUOut = 32'h100 + 32'(i);
            in_rd = 5'(i + 10);
            step();
            chk("pt_b2b_ov", 32'(out_valid), 1);
            chk("pt_b2b_data", out_data, 32'h100 + 32'(i));
            chk("pt_b2b_rd", 32'(out_rd), 32'(i + 10));
            chk("pt_b2b_req", 32'(mem_req), 0);
        end
        idle_in();
        step();
        chk("pt_end_ov", 32'(out_valid), 0);
        chk("pt_end_rw", 32'(out_regWrite), 0);
        chk("pt_end_hold", out_data, 32'h103);
        do_load("lb", 32'h0000_1003, 3'b000, 32'h8000_0000, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
        do_load("lbu", 32'h0000_1003, 3'b100, 32'h8000_0000, 32'h0000_1000, 4'b1000, 32'h0000_0080);
        do_load("lh", 32'h0000_1002, 3'b001, 32'h8001_7FFF, 32'h0000_1000, 4'b1100, 32'hFFFF_8001);
        do_load("lhu", 32'h0000_1000, 3'b101, 32'h8001_F00D, 32'h0000_1000, 4'b0011, 32'h0000_F00D);
        do_load("lb1", 32'h0000_1001, 3'b000, 32'h0000_7F00, 32'h0000_1000, 4'b0010, 32'h0000_007F);
        do_load("lw", 32'h0000_1004, 3'b010, 32'hCAFE_0123, 32'h0000_1004, 4'b1111, 32'hCAFE_0123);
        op(32'h0000_2002, 1'b0, 1'b1, 3'b001, 5'd9, 1'b1, 32'h0000_ABCD);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) idle_in();
            chk("sh_req", 32'(mem_req), 1);
            chk("sh_we", 32'(mem_we), 1);
            chk("sh_addr", mem_addr, 32'h0000_2000);
            chk("sh_be", 32'(mem_be), 32'b1100);
            chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
            chk("sh_rdy", 32'(in_ready), 0);
            chk("sh_nov", 32'(out_valid), 0);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("sh_ov", 32'(out_valid), 1);
        chk("sh_rw", 32'(out_regWrite), 0);
        chk("sh_data", out_data, 0);
        chk("sh_rd", 32'(out_rd), 9);
        chk("sh_rdy1", 32'(in_ready), 1);
        op(32'h0000_3001, 1'b0, 1'b1, 3'b000, 5'd1, 1'b0, 32'h1234_56A5);
        step();
        idle_in();
        chk("sb_be", 32'(mem_be), 32'b0010);
        chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("sb_ov", 32'(out_valid), 1);
        op(32'h0000_1002, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1, '0);
        step();
        chk("flw_ov", 32'(out_valid), 1);
        chk("flw_fault", 32'(out_fault), 1);
        chk("flw_data", out_data, 32'h0000_1002);
        chk("flw_rw", 32'(out_regWrite), 0);
        chk("flw_req", 32'(mem_req), 0);
        chk("flw_rdy", 32'(in_ready), 1);
        op(32'h0000_3000, 1'b1, 1'b1, 3'b000, 5'd4, 1'b1, '0);
        step();
        chk("frw_fault", 32'(out_fault), 1);
        chk("frw_data", out_data, 32'h0000_3000);
        chk("frw_rw", 32'(out_regWrite), 0);
        chk("frw_req", 32'(mem_req), 0);
        op(32'h0000_3001, 1'b1, 1'b0, 3'b101, 5'd4, 1'b1, '0);
        step();
        chk("flhu_fault", 32'(out_fault), 1);
        op(32'h0000_3000, 1'b0, 1'b1, 3'b011, 5'd4, 1'b0, '0);
        step();
        chk("fsd_fault", 32'(out_fault), 1);
        op(32'h0000_3000, 1'b1, 1'b0, 3'b110, 5'd4, 1'b1, '0);
        step();
        chk("fl6_fault", 32'(out_fault), 1);
        chk("fl6_req", 32'(mem_req), 0);
        op(32'h0000_0042, 1'b0, 1'b0, 3'b000, 5'd3, 1'b1, '0);
        step();
        idle_in();
        chk("clr_fault", 32'(out_fault), 0);
        chk("clr_data", out_data, 32'h42);
        op(32'h0000_4000, 1'b1, 1'b0, 3'b010, 5'd6, 1'b1, '0);
        step();
        idle_in();
        chk("rmt_req1", 32'(mem_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("rmt_req0", 32'(mem_req), 0);
        chk("rmt_rdy", 32'(in_ready), 1);
        chk("rmt_ov", 32'(out_valid), 0);
        #1 rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        chk("rmt_late_ov", 32'(out_valid), 0);
        chk("rmt_late_req", 32'(mem_req), 0);
        chk("rmt_late_rdy", 32'(in_ready), 1);
        step();
        chk("sp_ov", 32'(out_valid), 0);
        chk("sp_req", 32'(mem_req), 0);
        chk("sp_rdy", 32'(in_ready), 1);
        mem_ack = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
